// File: rtl/risc_cpu_if.sv
// Memory bus between the risc_cpu core and its shared program/data memory.
// Semantics: rd qualifies rdata combinationally in the same cycle; wr commits wdata at addr on the next rising edge of clk; no wait states.
interface risc_cpu_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic [AWIDTH-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rdata;

  modport master (output addr, rd, wr, wdata, input rdata);
  modport slave  (input addr, rd, wr, wdata, output rdata);
endinterface

// File: rtl/risc_cpu.sv
// 8-bit accumulator CPU: eight-phase controller, pc/ir/ac datapath and a shared 2^AWIDTH-word memory.
// Optional RISC_HALT_FREEZE_EN: a HLT parks the controller in OP_ADDR until rst.
module risc_memory #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input logic        clk,
  risc_cpu_if.slave  bus
);
  reg [DWIDTH-1:0] array [0:(1<<AWIDTH)-1];

  assign bus.rdata = bus.rd ? array[bus.addr] : '0;

  // Contents deliberately survive rst so a preloaded program can be rerun.
  always_ff @(posedge clk) begin
    if (bus.wr) array[bus.addr] <= bus.wdata;
  end
endmodule

module risc_cpu #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  output logic halt
);
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_t;

  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } opcode_t;

  phase_t            phase;
  phase_t            phase_next;
  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] ac;
  logic [DWIDTH-1:0] alu_out;
  logic [DWIDTH-1:0] data;
  opcode_t           opcode;
  logic [AWIDTH-1:0] operand;
  logic              zero;
  logic              aluop;
  logic              sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc;

  risc_cpu_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) mem_bus ();

  risc_memory #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) memory_inst (
    .clk (clk),
    .bus (mem_bus.slave)
  );

  assign opcode        = opcode_t'(ir[DWIDTH-1 -: 3]);
  assign operand       = ir[AWIDTH-1:0];
  assign zero          = (ac == '0);
  assign aluop         = (opcode == OP_ADD) || (opcode == OP_AND) ||
                         (opcode == OP_XOR) || (opcode == OP_LDA);
  assign mem_bus.addr  = sel ? pc : operand;
  assign mem_bus.rd    = rd;
  assign mem_bus.wr    = wr;
  assign mem_bus.wdata = ac;
  assign data          = mem_bus.rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= INST_ADDR;
    else     phase <= phase_next;
  end

  always_comb begin
    phase_next = phase_t'(phase + 3'd1);
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    case (phase)
      INST_ADDR:  sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = (opcode != OP_HLT);
        halt   = (opcode == OP_HLT);
`ifdef RISC_HALT_FREEZE_EN
        if (opcode == OP_HLT) phase_next = phase;
`endif
      end
      OP_FETCH: rd = aluop;
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
      end
      STORE: begin
        rd    = aluop;
        ld_ac = aluop;
        ld_pc = (opcode == OP_JMP);
        wr    = (opcode == OP_STO);
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_out = ac;
    case (opcode)
      OP_ADD:  alu_out = ac + data;
      OP_AND:  alu_out = ac & data;
      OP_XOR:  alu_out = ac ^ data;
      OP_LDA:  alu_out = data;
      default: alu_out = ac;
    endcase
  end

  // SKZ skips by incrementing in both OP_ADDR and ALU_OP; JMP overrides the OP_ADDR increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
      ac <= '0;
    end else begin
      if (ld_ir)       ir <= data;
      if (ld_pc)       pc <= operand;
      else if (inc_pc) pc <= pc + 1'b1;
      if (ld_ac)       ac <= alu_out;
    end
  end
endmodule

// File: tb/tb_risc_cpu.sv
// Bench for risc_cpu: directed programs plus random memory images, checked against an instruction-level model.
module tb_risc_cpu;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt;

  always #5 clk = ~clk;

  risc_cpu #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];     // expected pc at each instruction boundary
  logic [DW-1:0] exp_ac_q[$];  // expected ac at each instruction boundary
  int            ref_halt_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  // ---------------- reference model: one instruction per step ----------------
  task automatic run_model(input int max_instr);
    int pc, ac, op, a;
    pc = 0;
    ac = 0;
    ref_halt_idx = -1;
    exp_q.delete();
    exp_ac_q.delete();
    exp_q.push_back(8'(pc));
    exp_ac_q.push_back(8'(ac));
    for (int n = 0; n < max_instr; n++) begin
      op = int'(ref_mem[pc]) / 32;
      a  = int'(ref_mem[pc]) % 32;
      if (op == 0) begin
        ref_halt_idx = n;
        break;
      end
      case (op)
        1: pc = (pc + ((ac == 0) ? 2 : 1)) % DEPTH;
        2: begin ac = (ac + int'(ref_mem[a])) % 256; pc = (pc + 1) % DEPTH; end
        3: begin ac = ac & int'(ref_mem[a]);         pc = (pc + 1) % DEPTH; end
        4: begin ac = ac ^ int'(ref_mem[a]);         pc = (pc + 1) % DEPTH; end
        5: begin ac = int'(ref_mem[a]);              pc = (pc + 1) % DEPTH; end
        6: begin ref_mem[a] = 8'(ac);                pc = (pc + 1) % DEPTH; end
        default: pc = a;
      endcase
      exp_q.push_back(8'(pc));
      exp_ac_q.push_back(8'(ac));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic hold_reset_and_preload();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) dut.memory_inst.array[i] = ref_mem[i];
  endtask

  function automatic logic halt_expected(input int c, input int h);
    if (h < 0) return 1'b0;
`ifdef RISC_HALT_FREEZE_EN
    return c >= 8 * h + 4;
`else
    return (c % 8 == 4) && (c / 8 >= h);
`endif
  endfunction

  task automatic run_and_check(input string name, input int max_instr, input int spec_clock);
    int total, first_halt;
    logic [DW-1:0] e_pc, e_ac;
    hold_reset_and_preload();
    run_model(max_instr);
    total = (ref_halt_idx >= 0) ? 8 * ref_halt_idx + 20 : 8 * max_instr;
    first_halt = -1;
    e_pc = exp_q.pop_front();
    e_ac = exp_ac_q.pop_front();
    check({name, ":reset_halt"}, halt, 1'b0);
    check({name, ":reset_pc"}, dut.pc, e_pc);
    check({name, ":reset_ac"}, dut.ac, e_ac);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk);
      #1;
      check({name, ":halt"}, halt, halt_expected(c, ref_halt_idx));
      if (halt && first_halt < 0) first_halt = c;
      if (c % 8 == 0 && exp_q.size() > 0) begin
        e_pc = exp_q.pop_front();
        e_ac = exp_ac_q.pop_front();
        check({name, ":pc"}, dut.pc, e_pc);
        check({name, ":ac"}, dut.ac, e_ac);
      end
    end
    if (spec_clock >= 0) check({name, ":halt_clock"}, first_halt - 1, spec_clock);
    for (int i = 0; i < DEPTH; i++) check({name, ":mem"}, dut.memory_inst.array[i], ref_mem[i]);
  endtask

  // ---------------- directed programs ----------------
  task automatic load_and_xor(input logic [2:0] op, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2);
    clear_mem();
    ref_mem[0]  = ins(3'd5, 5'd10);
    ref_mem[1]  = ins(op, 5'd11);
    ref_mem[2]  = ins(3'd1, 5'd0);
    ref_mem[3]  = ins(3'd7, 5'd5);
    ref_mem[4]  = ins(3'd0, 5'd0);
    ref_mem[5]  = ins(op, 5'd12);
    ref_mem[6]  = ins(3'd1, 5'd0);
    ref_mem[7]  = ins(3'd0, 5'd0);
    ref_mem[8]  = ins(3'd7, 5'd9);
    ref_mem[9]  = ins(3'd0, 5'd0);
    ref_mem[10] = d0;
    ref_mem[11] = d1;
    ref_mem[12] = d2;
  endtask

  task automatic load_add_prog();
    clear_mem();
    ref_mem[0]  = ins(3'd5, 5'd9);
    ref_mem[1]  = ins(3'd2, 5'd11);
    ref_mem[2]  = ins(3'd1, 5'd0);
    ref_mem[3]  = ins(3'd0, 5'd0);
    ref_mem[4]  = ins(3'd2, 5'd11);
    ref_mem[5]  = ins(3'd1, 5'd0);
    ref_mem[6]  = ins(3'd0, 5'd0);
    ref_mem[9]  = 8'hff;
    ref_mem[11] = 8'h01;
  endtask

  initial begin
    // HLT at address 0
    clear_mem();
    run_and_check("hlt", 4, 3);

    // JMP
    clear_mem();
    ref_mem[0] = ins(3'd7, 5'd2);
    ref_mem[1] = ins(3'd7, 5'd2);
    run_and_check("jmp", 4, 11);

    // SKZ with ac=0 skips a self-loop
    clear_mem();
    ref_mem[0] = ins(3'd1, 5'd0);
    ref_mem[1] = ins(3'd7, 5'd1);
    run_and_check("skz_taken", 4, 11);

    // LDA nonzero, SKZ falls through
    clear_mem();
    ref_mem[0] = ins(3'd5, 5'd5);
    ref_mem[1] = ins(3'd1, 5'd0);
    ref_mem[5] = 8'h01;
    run_and_check("lda_skz", 6, 19);

    // STO
    clear_mem();
    ref_mem[0] = ins(3'd5, 5'd7);
    ref_mem[1] = ins(3'd6, 5'd8);
    ref_mem[2] = ins(3'd5, 5'd8);
    ref_mem[3] = ins(3'd1, 5'd0);
    ref_mem[4] = ins(3'd0, 5'd0);
    ref_mem[5] = ins(3'd7, 5'd6);
    ref_mem[6] = ins(3'd0, 5'd0);
    ref_mem[7] = 8'h01;
    ref_mem[8] = 8'h00;
    run_and_check("sto", 10, 35);
    check("sto:mem8", dut.memory_inst.array[8], 8'h01);

    load_and_xor(3'd3, 8'hff, 8'h01, 8'hfe);
    run_and_check("and", 12, 59);
    load_and_xor(3'd4, 8'h55, 8'h54, 8'h01);
    run_and_check("xor", 12, 59);

    load_add_prog();
    run_and_check("add_wrap", 10, 43);

    // Asynchronous reset in the middle of the second instruction
    load_add_prog();
    hold_reset_and_preload();
    @(negedge clk);
    rst = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("midrst:ac_before", dut.ac, 8'hff);
    #2;
    rst = 1'b1;
    #1;
    check("midrst:halt", halt, 1'b0);
    check("midrst:pc", dut.pc, 0);
    check("midrst:ac", dut.ac, 0);
    check("midrst:phase", dut.phase, 0);
    run_and_check("add_after_rst", 10, 43);

    // Random memory images
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom_range(0, 255));
      run_and_check($sformatf("rand%0d", t), 30, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
